// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency results queue in a FIFO.
// Define WB_ARB_PERF_EN to add saturating steal / FIFO-full cycle counters.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int RADDR_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_valid,
    input  logic [RADDR_W-1:0]   pipe_rd,
    input  logic [`WORD_LEN-1:0] pipe_wb_data,
    input  logic                 mdu_valid,
    output logic                 mdu_ready,
    input  logic [RADDR_W-1:0]   mdu_rd,
    input  logic [`WORD_LEN-1:0] mdu_data,
    output logic                 stall_pipe,
    output logic                 rf_we,
    output logic [RADDR_W-1:0]   rf_waddr,
    output logic [`WORD_LEN-1:0] rf_wdata,
    input  logic [RADDR_W-1:0]   chk_rd,
    output logic                 chk_hit
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]          perf_steals,
    output logic [31:0]          perf_full_cycles
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        STEAL
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [RADDR_W-1:0]   fifo_rd_q   [DEPTH];
    logic [`WORD_LEN-1:0] fifo_data_q [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic push;
    logic pop;
    logic pipe_write;
    logic [DEPTH-1:0] hit_vec;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign mdu_ready  = ~rst & ~fifo_full;
    assign accept     = mdu_valid & mdu_ready;
    assign push       = accept & (mdu_rd != '0);

    assign stall_pipe = (state_q == STEAL);
    assign pipe_write = pipe_valid & (pipe_rd != '0);
    assign pop        = ~fifo_empty & (stall_pipe | ~pipe_write);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst) begin
            if (pop) begin
                rf_we    = 1'b1;
                rf_waddr = fifo_rd_q[rd_ptr_q];
                rf_wdata = fifo_data_q[rd_ptr_q];
            end else if (pipe_write) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_rd;
                rf_wdata = pipe_wb_data;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (push) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (pop) begin
                    wait_cnt_d = '0;
                    if (count_d == '0) begin
                        state_d = IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    // Steal on starvation, or when the FIFO fills so the unit is not blocked for long.
                    if ((wait_cnt_d == WAIT_W'(MAX_WAIT)) || (count_d == CNT_W'(DEPTH))) begin
                        state_d = STEAL;
                    end
                end
            end
            STEAL: begin
                wait_cnt_d = '0;
                state_d    = (count_d == '0) ? IDLE : PENDING;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mdu_rd;
            fifo_data_q[wr_ptr_q] <= mdu_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chk
        logic [PTR_W-1:0] offset;
        assign offset      = PTR_W'(gi) - rd_ptr_q;
        assign hit_vec[gi] = ({1'b0, offset} < count_q) && (fifo_rd_q[gi] == chk_rd);
    end

    assign chk_hit = (chk_rd != '0) && (|hit_vec);

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_steals_q;
    logic [31:0] perf_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_steals_q <= '0;
            perf_full_q   <= '0;
        end else begin
            if (stall_pipe && (perf_steals_q != '1)) begin
                perf_steals_q <= perf_steals_q + 32'd1;
            end
            if (fifo_full && (perf_full_q != '1)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign perf_steals      = perf_steals_q;
    assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand sequences, and a randomized
// run compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam int RADDR_W  = 5;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_rd;
    logic        chk_hit;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_steals;
    logic [31:0] perf_full_cycles;
`endif

    wb_port_arbiter #(
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_wb_data(pipe_wb_data),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .stall_pipe  (stall_pipe),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .chk_rd      (chk_rd),
        .chk_hit     (chk_hit)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_steals     (perf_steals),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic [4:0]  crd;
        logic        rdy;
        logic        stall;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        hit;
    } vec_t;

    int n_cmp;
    int n_bad;
    int step_no;

    // Reference model: pending long-latency results in arrival order.
    logic [4:0]  mq_rd[$];
    logic [31:0] mq_data[$];
    int          denied;
    bit          steal_pend;

    function automatic vec_t mk(input logic [31:0] pv, input logic [31:0] prd, input logic [31:0] pdata,
                                input logic [31:0] mv, input logic [31:0] mrd, input logic [31:0] mdata,
                                input logic [31:0] crd, input logic [31:0] rdy, input logic [31:0] stall,
                                input logic [31:0] we, input logic [31:0] waddr, input logic [31:0] wdata,
                                input logic [31:0] hit);
        vec_t v;
        v.pv    = pv[0];
        v.prd   = prd[4:0];
        v.pdata = pdata;
        v.mv    = mv[0];
        v.mrd   = mrd[4:0];
        v.mdata = mdata;
        v.crd   = crd[4:0];
        v.rdy   = rdy[0];
        v.stall = stall[0];
        v.we    = we[0];
        v.waddr = waddr[4:0];
        v.wdata = wdata;
        v.hit   = hit[0];
        return v;
    endfunction

    task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d %s: got %0h want %0h", tag, step_no, name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_rd.delete();
        mq_data.delete();
        denied     = 0;
        steal_pend = 1'b0;
    endtask

    // Entered at posedge+1; drives, checks mid-cycle, advances the model, returns at next posedge+1.
    task automatic step(input vec_t v, input bit use_model, input string tag);
        vec_t e;
        vec_t x;
        bit   head_wr;
        bit   nonempty;
        bit   acc;
        pipe_valid   = v.pv;
        pipe_rd      = v.prd;
        pipe_wb_data = v.pdata;
        mdu_valid    = v.mv;
        mdu_rd       = v.mrd;
        mdu_data     = v.mdata;
        chk_rd       = v.crd;
        #2;
        e       = v;
        e.rdy   = (mq_rd.size() < DEPTH);
        e.stall = steal_pend;
        head_wr = steal_pend || (!(v.pv && v.prd != 0) && mq_rd.size() > 0);
        if (head_wr) begin
            e.we    = 1'b1;
            e.waddr = mq_rd[0];
            e.wdata = mq_data[0];
        end else if (v.pv && v.prd != 0) begin
            e.we    = 1'b1;
            e.waddr = v.prd;
            e.wdata = v.pdata;
        end else begin
            e.we    = 1'b0;
            e.waddr = '0;
            e.wdata = '0;
        end
        e.hit = 1'b0;
        if (v.crd != 0) begin
            foreach (mq_rd[k]) if (mq_rd[k] == v.crd) e.hit = 1'b1;
        end
        x = use_model ? e : v;
        check(tag, "mdu_ready", {31'b0, mdu_ready}, {31'b0, x.rdy});
        check(tag, "stall_pipe", {31'b0, stall_pipe}, {31'b0, x.stall});
        check(tag, "rf_we", {31'b0, rf_we}, {31'b0, x.we});
        if (x.we) begin
            check(tag, "rf_waddr", {27'b0, rf_waddr}, {27'b0, x.waddr});
            check(tag, "rf_wdata", rf_wdata, x.wdata);
        end
        check(tag, "chk_hit", {31'b0, chk_hit}, {31'b0, x.hit});

        nonempty = (mq_rd.size() > 0);
        acc      = v.mv && e.rdy && (v.mrd != 0);
        if (head_wr) begin
            void'(mq_rd.pop_front());
            void'(mq_data.pop_front());
            denied = 0;
        end else if (nonempty) begin
            denied++;
        end
        if (acc) begin
            mq_rd.push_back(v.mrd);
            mq_data.push_back(v.mdata);
        end
        steal_pend = nonempty && !head_wr && (denied >= MAX_WAIT || mq_rd.size() == DEPTH);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];
    vec_t rv;
    int   busy;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        step_no = 0;
        model_reset();

        rst          = 1'b1;
        pipe_valid   = 1'b1;
        pipe_rd      = 5'd3;
        pipe_wb_data = 32'h0000_1234;
        mdu_valid    = 1'b0;
        mdu_rd       = '0;
        mdu_data     = '0;
        chk_rd       = 5'd3;
        #1;
        check("reset", "rf_we", {31'b0, rf_we}, 32'd0);
        check("reset", "stall_pipe", {31'b0, stall_pipe}, 32'd0);
        check("reset", "chk_hit", {31'b0, chk_hit}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //             pv prd pdata         mv mrd mdata         crd rdy st we wa wdata         hit
        tbl[0] = mk(1, 3, 32'h0000_1234, 0, 0,  32'h0,        0,  1, 0, 1, 3,  32'h0000_1234, 0);
        tbl[1] = mk(0, 0, 32'h0,         1, 7,  32'h0000_BEEF, 7, 1, 0, 0, 0,  32'h0,         0);
        tbl[2] = mk(0, 0, 32'h0,         0, 0,  32'h0,        7,  1, 0, 1, 7,  32'h0000_BEEF, 1);
        tbl[3] = mk(0, 0, 32'h0,         0, 0,  32'h0,        7,  1, 0, 0, 0,  32'h0,         0);
        tbl[4] = mk(0, 0, 32'h0,         1, 0,  32'h5,        0,  1, 0, 0, 0,  32'h0,         0);
        tbl[5] = mk(1, 0, 32'h55,        0, 0,  32'h0,        0,  1, 0, 0, 0,  32'h0,         0);
        tbl[6] = mk(1, 4, 32'h44,        1, 12, 32'h0000_C0DE, 12, 1, 0, 1, 4, 32'h44,        0);
        tbl[7] = mk(1, 4, 32'h45,        0, 0,  32'h0,        12, 1, 0, 1, 4,  32'h45,        1);
        tbl[8] = mk(0, 0, 32'h0,         0, 0,  32'h0,        0,  1, 0, 1, 12, 32'h0000_C0DE, 0);
        tbl[9] = mk(0, 0, 32'h0,         0, 0,  32'h0,        12, 1, 0, 0, 0,  32'h0,         0);
        for (int i = 0; i < 10; i++) step(tbl[i], 1'b0, "table");

        // Starvation: head denied MAX_WAIT cycles, then one steal cycle.
        step(mk(1, 2, 32'h2222_0000, 1, 9, 32'h9999, 0, 1, 0, 1, 2, 32'h2222_0000, 0), 1'b0, "starve_push");
        for (int i = 0; i < MAX_WAIT; i++)
            step(mk(1, 2, 32'h2222_0001 + i, 0, 0, 0, 9, 1, 0, 1, 2, 32'h2222_0001 + i, 1), 1'b0, "starve_deny");
        step(mk(1, 2, 32'h2222_00FF, 0, 0, 0, 9, 1, 1, 1, 9, 32'h9999, 1), 1'b0, "starve_steal");
        step(mk(1, 2, 32'h2222_0100, 0, 0, 0, 9, 1, 0, 1, 2, 32'h2222_0100, 0), 1'b0, "starve_after");

        // Full FIFO under a busy pipe: ready drops, steal follows immediately, 5th offer rejected.
        step(mk(1, 2, 32'hA000_0001, 1, 10, 32'hA10, 0,  1, 0, 1, 2, 32'hA000_0001, 0), 1'b0, "full");
        step(mk(1, 2, 32'hA000_0002, 1, 11, 32'hA11, 10, 1, 0, 1, 2, 32'hA000_0002, 1), 1'b0, "full");
        step(mk(1, 2, 32'hA000_0003, 1, 13, 32'hA13, 0,  1, 0, 1, 2, 32'hA000_0003, 0), 1'b0, "full");
        step(mk(1, 2, 32'hA000_0004, 1, 14, 32'hA14, 14, 1, 0, 1, 2, 32'hA000_0004, 0), 1'b0, "full");
        step(mk(1, 2, 32'hA000_0005, 1, 15, 32'hA15, 14, 0, 1, 1, 10, 32'hA10, 1), 1'b0, "full_steal");
        step(mk(1, 2, 32'hA000_0006, 0, 0, 0, 15, 1, 0, 1, 2, 32'hA000_0006, 0), 1'b0, "full_after");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 11, 32'hA11, 0), 1'b0, "full_drain");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 13, 32'hA13, 0), 1'b0, "full_drain");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 14, 32'hA14, 0), 1'b0, "full_drain");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "full_empty");

        // Reset asserted in the middle of a steal cycle.
        step(mk(1, 2, 32'h3000_0001, 1, 20, 32'h2020, 0,  1, 0, 1, 2, 32'h3000_0001, 0), 1'b0, "rs_fill");
        step(mk(1, 2, 32'h3000_0002, 1, 21, 32'h2121, 20, 1, 0, 1, 2, 32'h3000_0002, 1), 1'b0, "rs_fill");
        step(mk(1, 2, 32'h3000_0003, 1, 22, 32'h2222, 0,  1, 0, 1, 2, 32'h3000_0003, 0), 1'b0, "rs_fill");
        step(mk(1, 2, 32'h3000_0004, 1, 23, 32'h2323, 0,  1, 0, 1, 2, 32'h3000_0004, 0), 1'b0, "rs_fill");
        pipe_valid   = 1'b1;
        pipe_rd      = 5'd2;
        pipe_wb_data = 32'h3000_0005;
        mdu_valid    = 1'b1;
        mdu_rd       = 5'd24;
        mdu_data     = 32'h2424;
        chk_rd       = 5'd20;
        #2;
        check("rs_pre", "stall_pipe", {31'b0, stall_pipe}, 32'd1);
        check("rs_pre", "rf_we", {31'b0, rf_we}, 32'd1);
        check("rs_pre", "rf_waddr", {27'b0, rf_waddr}, 32'd20);
        check("rs_pre", "chk_hit", {31'b0, chk_hit}, 32'd1);
        rst = 1'b1;
        #1;
        check("rs_mid", "stall_pipe", {31'b0, stall_pipe}, 32'd0);
        check("rs_mid", "rf_we", {31'b0, rf_we}, 32'd0);
        check("rs_mid", "chk_hit", {31'b0, chk_hit}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 21, 1, 0, 0, 0, 0, 0), 1'b0, "rs_after");
        step(mk(0, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0), 1'b0, "rs_after");

        // Randomized traffic at three pipeline load levels.
        for (int seg = 0; seg < 3; seg++) begin
            busy = (seg == 0) ? 50 : ((seg == 1) ? 90 : 100);
            for (int i = 0; i < 1000; i++) begin
                rv       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                rv.pv    = ($urandom_range(0, 99) < busy);
                rv.prd   = 5'($urandom_range(0, 31));
                rv.pdata = $urandom;
                rv.mv    = ($urandom_range(0, 99) < 40);
                rv.mrd   = 5'($urandom_range(0, 31));
                rv.mdata = $urandom;
                if (mq_rd.size() > 0 && $urandom_range(0, 1) == 1)
                    rv.crd = mq_rd[$urandom_range(0, mq_rd.size() - 1)];
                else
                    rv.crd = 5'($urandom_range(0, 31));
                step(rv, 1'b1, "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
